// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester round-robin mux arbiter.
package mux_arb_pkg;
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] GRANT_A = 2'b01;
  localparam logic [1:0] GRANT_B = 2'b10;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux_w2to1.sv
// Purely combinational 2:1 mux; S=0 passes A, S=1 passes B.
module mux_w2to1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  output logic [WIDTH-1:0] Y
);
  assign Y = S ? B : A;
endmodule

// File: rtl/mux_rr_arbiter.sv
// Packet-based round-robin arbiter sharing one ready/valid sink between two
// requesters; a grant lasts until the owner's last beat or MAX_BEATS beats.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  output logic             ack_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  logic [1:0]    r_state, w_state_nxt;
  logic          r_prio, w_prio_nxt;
  logic          r_sel, w_sel_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic w_grant_a, w_grant_b, w_accept, w_release;

  mux_w2to1 #(.WIDTH(WIDTH)) u_mux_data (
    .A(data_a), .B(data_b), .S(r_sel), .Y(out_data)
  );

  mux_w2to1 #(.WIDTH(1)) u_mux_last (
    .A(last_a), .B(last_b), .S(r_sel), .Y(out_last)
  );

  assign w_grant_a = (r_state == GRANT_A);
  assign w_grant_b = (r_state == GRANT_B);
  assign out_valid = (w_grant_a & req_a) | (w_grant_b & req_b);
  assign ack_a     = w_grant_a & req_a & out_ready;
  assign ack_b     = w_grant_b & req_b & out_ready;
  assign busy      = (r_state != IDLE);
  assign sel       = r_sel;

  // sel always matches the grant, so out_last is the owner's last flag
  assign w_accept  = ack_a | ack_b;
  assign w_release = w_accept & (out_last | (r_cnt == LAST_CNT));

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_a && (!req_b || r_prio == SEL_A)) begin
          w_state_nxt = GRANT_A;
          w_sel_nxt   = SEL_A;
        end else if (req_b) begin
          w_state_nxt = GRANT_B;
          w_sel_nxt   = SEL_B;
        end
      end
      GRANT_A: begin
        if (w_release) begin
          w_cnt_nxt  = '0;
          w_prio_nxt = SEL_B;
          if (req_b) begin
            w_state_nxt = GRANT_B;
            w_sel_nxt   = SEL_B;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_accept) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      GRANT_B: begin
        if (w_release) begin
          w_cnt_nxt  = '0;
          w_prio_nxt = SEL_A;
          if (req_a) begin
            w_state_nxt = GRANT_A;
            w_sel_nxt   = SEL_A;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_accept) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= SEL_A;
      r_sel   <= SEL_A;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: queued source models drive A/B, a monitor
// pops expected {sel,last,data} on every accepted output beat.
module tb_mux_rr_arbiter;
  logic       clk, rst;
  logic       req_a, last_a, ack_a, req_b, last_b, ack_b;
  logic [7:0] data_a, data_b, out_data;
  logic       out_valid, out_last, out_ready, sel, busy;
  logic       drv_req_a, drv_req_b, hold_a;
  logic       take_a, take_b;

  logic [8:0] src_a[$];
  logic [8:0] src_b[$];
  logic [9:0] expq[$];

  int checks, errors;

  assign req_a = drv_req_a && !hold_a;
  assign req_b = drv_req_b;

  mux_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .last_a(last_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .last_b(last_b), .ack_b(ack_b),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel(sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Source models: pop on the beat accepted at the previous edge
  initial begin
    drv_req_a = 1'b0; drv_req_b = 1'b0;
    data_a = '0; last_a = 1'b0; data_b = '0; last_b = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (take_a && src_a.size() > 0) void'(src_a.pop_front());
      if (take_b && src_b.size() > 0) void'(src_b.pop_front());
      if (src_a.size() > 0) begin
        drv_req_a = 1'b1;
        {last_a, data_a} = src_a[0];
      end else drv_req_a = 1'b0;
      if (src_b.size() > 0) begin
        drv_req_b = 1'b1;
        {last_b, data_b} = src_b[0];
      end else drv_req_b = 1'b0;
    end
  end

  // Monitor: compare every accepted output beat against the scoreboard
  initial begin
    logic [9:0] e;
    take_a = 1'b0; take_b = 1'b0;
    forever begin
      @(negedge clk);
      take_a = ack_a;
      take_b = ack_b;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t",
                   {sel, out_last, out_data}, $time);
        end else begin
          e = expq.pop_front();
          chk("beat", {22'd0, sel, out_last, out_data}, {22'd0, e});
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sel, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || src_a.size() != 0 || src_b.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, expq.size() + src_a.size() + src_b.size(), 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; out_ready = 1'b1; hold_a = 1'b0;
    tick();
    chk("reset_valid", out_valid, 0);
    chk("reset_acks", {ack_a, ack_b}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sel", sel, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // single-beat packet from A
    src_a.push_back({1'b1, 8'h3C});
    expq.push_back({1'b0, 1'b1, 8'h3C});
    tick();
    chk("t1_not_yet", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'h3C);
    chk("t1_ack", ack_a, 1);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_valid_low", out_valid, 0);

    // alternating 2-beat packets, no bubbles
    do_reset();
    for (int i = 0; i < 2; i++) begin
      src_a.push_back({1'b0, 8'h11 + 8'(2*i)});
      src_a.push_back({1'b1, 8'h12 + 8'(2*i)});
      src_b.push_back({1'b0, 8'h21 + 8'(2*i)});
      src_b.push_back({1'b1, 8'h22 + 8'(2*i)});
    end
    expq.push_back({1'b0, 1'b0, 8'h11}); expq.push_back({1'b0, 1'b1, 8'h12});
    expq.push_back({1'b1, 1'b0, 8'h21}); expq.push_back({1'b1, 1'b1, 8'h22});
    expq.push_back({1'b0, 1'b0, 8'h13}); expq.push_back({1'b0, 1'b1, 8'h14});
    expq.push_back({1'b1, 1'b0, 8'h23}); expq.push_back({1'b1, 1'b1, 8'h24});
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    for (int i = 0; i < 8; i++) begin
      chk("t2_no_bubble", out_valid, 1);
      tick();
    end
    drain("t2");

    // forced release after 4 beats, B interleaves
    do_reset();
    for (int i = 0; i < 6; i++) src_a.push_back({(i == 5), 8'hA0 + 8'(i)});
    src_b.push_back({1'b1, 8'hB0});
    for (int i = 0; i < 4; i++) expq.push_back({1'b0, 1'b0, 8'hA0 + 8'(i)});
    expq.push_back({1'b1, 1'b1, 8'hB0});
    expq.push_back({1'b0, 1'b0, 8'hA4});
    expq.push_back({1'b0, 1'b1, 8'hA5});
    drain("t3");

    // sink stall mid-packet
    do_reset();
    src_a.push_back({1'b0, 8'hC0});
    src_a.push_back({1'b0, 8'hC1});
    src_a.push_back({1'b1, 8'hC2});
    expq.push_back({1'b0, 1'b0, 8'hC0});
    expq.push_back({1'b0, 1'b0, 8'hC1});
    expq.push_back({1'b0, 1'b1, 8'hC2});
    tick();
    tick();
    @(posedge clk);
    #2 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_valid", out_valid, 1);
      chk("t4_data", out_data, 8'hC1);
      chk("t4_ack", ack_a, 0);
      chk("t4_cnt", dut.r_cnt, 1);
      chk("t4_grant", {busy, sel}, 2'b10);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain("t4");

    // async reset during a B grant
    do_reset();
    src_b.push_back({1'b0, 8'hD0});
    src_b.push_back({1'b0, 8'hD1});
    src_b.push_back({1'b1, 8'hD2});
    expq.push_back({1'b1, 1'b0, 8'hD0});
    expq.push_back({1'b1, 1'b0, 8'hD1});
    expq.push_back({1'b1, 1'b1, 8'hD2});
    tick();
    tick();
    chk("t5_granted_b", {busy, sel}, 2'b11);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid_drop", out_valid, 0);
    chk("t5_ack_drop", ack_b, 0);
    chk("t5_sel", sel, 0);
    chk("t5_busy", busy, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    tick();
    chk("t5_regrant_b", {busy, sel}, 2'b11);
    drain("t5");

    // A drops req mid-packet while B waits
    do_reset();
    src_a.push_back({1'b0, 8'hE0});
    src_a.push_back({1'b0, 8'hE1});
    src_a.push_back({1'b1, 8'hE2});
    src_b.push_back({1'b1, 8'hF0});
    expq.push_back({1'b0, 1'b0, 8'hE0});
    expq.push_back({1'b0, 1'b0, 8'hE1});
    expq.push_back({1'b0, 1'b1, 8'hE2});
    expq.push_back({1'b1, 1'b1, 8'hF0});
    tick();
    tick();
    @(posedge clk);
    #2 hold_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t6_valid", out_valid, 0);
      chk("t6_grant", {busy, sel}, 2'b10);
      chk("t6_no_b", ack_b, 0);
    end
    @(posedge clk);
    #2 hold_a = 1'b0;
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
